// File: rtl/sim_harness_ctrl.sv
// ---------------------------------------------------------------------------
// sim_harness_ctrl
//   Sequencer between the simulator environment and SimTop. After reset it
//   holds the DUT in reset, runs a one-shot init handshake, then requests one
//   difftest step per cycle while counting cycles. It gates logging by a cycle
//   window and collects per-core trap reports. A single sticky finish is raised
//   with an exit code when the run ends.
//
// Ports
//   clock, reset          harness clock, synchronous active-high reset
//   cfg_max_cycles        RUN cycle limit, 0 = unlimited
//   cfg_log_begin/end     inclusive cycle window for log_enable
//   dut_reset             reset to SimTop
//   init_valid/ready      init handshake with the environment
//   step_valid, step_err  per-cycle step request and its error return
//   core_trap_valid/code  per-core trap pulse and code (0 = good)
//   cycle_cnt             cycles elapsed in RUN
//   log_enable            cycle_cnt inside the log window (registered)
//   finish, exit_code     sticky end flag; 0 good, 1 bad trap, 2 max, 3 err
//   bad_core              lowest core index reporting a bad trap
// ---------------------------------------------------------------------------
module sim_harness_ctrl #(
    parameter int unsigned N_CORES      = 1,
    parameter int unsigned RESET_CYCLES = 50,
    parameter int unsigned CYCLE_W      = 64,
    parameter int unsigned CODE_W       = 8
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [CYCLE_W-1:0]          cfg_max_cycles,
    input  logic [63:0]                 cfg_log_begin,
    input  logic [63:0]                 cfg_log_end,
    output logic                        dut_reset,
    output logic                        init_valid,
    input  logic                        init_ready,
    output logic                        step_valid,
    input  logic                        step_err,
    input  logic [N_CORES-1:0]          core_trap_valid,
    input  logic [N_CORES*CODE_W-1:0]   core_trap_code,
    output logic [CYCLE_W-1:0]          cycle_cnt,
    output logic                        log_enable,
    output logic                        finish,
    output logic [1:0]                  exit_code,
    output logic [3:0]                  bad_core
);

    localparam int unsigned HOLD_W = $clog2(RESET_CYCLES + 1);
    // Common width for comparing the cycle counter against the 64-bit window.
    localparam int unsigned CMP_W  = (CYCLE_W > 64) ? CYCLE_W : 64;

    typedef enum logic [1:0] {
        HOLD,
        INIT,
        RUN,
        DONE
    } state_t;

    state_t               state;
    logic [HOLD_W-1:0]    hold_cnt;
    logic [N_CORES-1:0]   trapped;

    logic [CYCLE_W-1:0]   cnt_inc;
    logic                 bad_hit;
    logic [3:0]           bad_idx;
    logic                 all_good;
    logic                 max_hit;
    logic                 end_hit;
    logic [1:0]           end_code;
    logic [3:0]           end_core;

    function automatic logic in_window(input logic [CYCLE_W-1:0] c,
                                       input logic [63:0] lo,
                                       input logic [63:0] hi);
        logic [CMP_W-1:0] cx;
        logic [CMP_W-1:0] lx;
        logic [CMP_W-1:0] hx;
        cx = CMP_W'(c);
        lx = CMP_W'(lo);
        hx = CMP_W'(hi);
        return (lx <= cx) && (cx <= hx);
    endfunction

    assign cnt_inc = cycle_cnt + CYCLE_W'(1);

    // Lowest-index core reporting a nonzero trap code this cycle.
    always_comb begin
        bad_hit = 1'b0;
        bad_idx = '0;
        for (int unsigned i = 0; i < N_CORES; i++) begin
            if (!bad_hit && core_trap_valid[i] &&
                core_trap_code[i*CODE_W +: CODE_W] != '0) begin
                bad_hit = 1'b1;
                bad_idx = 4'(i);
            end
        end
    end

    // Bad traps are checked first, so here every trap seen carried code 0.
    assign all_good = &(trapped | core_trap_valid);
    assign max_hit  = (cfg_max_cycles != '0) && (cnt_inc == cfg_max_cycles);

    // End-condition priority: step error, bad trap, all good, cycle limit.
    always_comb begin
        end_hit  = 1'b1;
        end_code = 2'd0;
        end_core = '0;
        if (step_err) begin
            end_code = 2'd3;
        end else if (bad_hit) begin
            end_code = 2'd1;
            end_core = bad_idx;
        end else if (all_good) begin
            end_code = 2'd0;
        end else if (max_hit) begin
            end_code = 2'd2;
        end else begin
            end_hit = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= HOLD;
            hold_cnt   <= '0;
            dut_reset  <= 1'b1;
            init_valid <= 1'b0;
            step_valid <= 1'b0;
            cycle_cnt  <= '0;
            finish     <= 1'b0;
            exit_code  <= 2'd0;
            bad_core   <= '0;
            trapped    <= '0;
            log_enable <= 1'b0;
        end else begin
            case (state)
                HOLD: begin
                    hold_cnt <= hold_cnt + HOLD_W'(1);
                    if (hold_cnt == HOLD_W'(RESET_CYCLES - 1)) begin
                        state      <= INIT;
                        dut_reset  <= 1'b0;
                        init_valid <= 1'b1;
                    end
                end
                INIT: begin
                    if (init_ready) begin
                        state      <= RUN;
                        init_valid <= 1'b0;
                        step_valid <= 1'b1;
                        // First RUN cycle shows cycle_cnt = 0.
                        log_enable <= in_window('0, cfg_log_begin, cfg_log_end);
                    end
                end
                RUN: begin
                    cycle_cnt <= cnt_inc;
                    trapped   <= trapped | core_trap_valid;
                    if (end_hit) begin
                        state      <= DONE;
                        finish     <= 1'b1;
                        step_valid <= 1'b0;
                        log_enable <= 1'b0;
                        exit_code  <= end_code;
                        bad_core   <= end_core;
                    end else begin
                        log_enable <= in_window(cnt_inc, cfg_log_begin, cfg_log_end);
                    end
                end
                DONE: begin
                end
                default: begin
                    state <= HOLD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sim_harness_ctrl.sv
module tb_sim_harness_ctrl;

    localparam int NC = 4;
    localparam int RC = 4;
    localparam int CW = 64;
    localparam int KW = 8;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [CW-1:0]     cfg_max_cycles = '0;
    logic [63:0]       cfg_log_begin = 64'd1;
    logic [63:0]       cfg_log_end = 64'd0;
    logic              dut_reset;
    logic              init_valid;
    logic              init_ready = 1'b0;
    logic              step_valid;
    logic              step_err = 1'b0;
    logic [NC-1:0]     core_trap_valid = '0;
    logic [NC*KW-1:0]  core_trap_code = '0;
    logic [CW-1:0]     cycle_cnt;
    logic              log_enable;
    logic              finish;
    logic [1:0]        exit_code;
    logic [3:0]        bad_core;

    sim_harness_ctrl #(
        .N_CORES(NC),
        .RESET_CYCLES(RC),
        .CYCLE_W(CW),
        .CODE_W(KW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .cfg_max_cycles(cfg_max_cycles),
        .cfg_log_begin(cfg_log_begin),
        .cfg_log_end(cfg_log_end),
        .dut_reset(dut_reset),
        .init_valid(init_valid),
        .init_ready(init_ready),
        .step_valid(step_valid),
        .step_err(step_err),
        .core_trap_valid(core_trap_valid),
        .core_trap_code(core_trap_code),
        .cycle_cnt(cycle_cnt),
        .log_enable(log_enable),
        .finish(finish),
        .exit_code(exit_code),
        .bad_core(bad_core)
    );

    always #5 clock = ~clock;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        else
            n_pass++;
    endtask

    // Reference model: time since reset fell, whether the handshake happened,
    // how many RUN cycles elapsed and the recorded outcome.
    int              m_t;
    bit              m_started;
    bit              m_done;
    longint unsigned m_runs;
    bit [NC-1:0]     m_trapped;
    int              m_exit;
    int              m_bad;
    bit              m_log;

    function automatic bit win(longint unsigned c);
        return (cfg_log_begin <= c) && (c <= cfg_log_end);
    endfunction

    task automatic model_edge();
        int ec;
        int bc;
        bit all;
        if (reset) begin
            m_t = 0; m_started = 0; m_done = 0; m_runs = 0;
            m_trapped = '0; m_exit = 0; m_bad = 0; m_log = 0;
        end else if (m_done) begin
        end else if (m_started) begin
            ec = -1; bc = 0;
            if (step_err) ec = 3;
            if (ec < 0)
                for (int i = 0; i < NC; i++)
                    if (ec < 0 && core_trap_valid[i] && core_trap_code[i*KW +: KW] != 0) begin
                        ec = 1; bc = i;
                    end
            if (ec < 0) begin
                all = 1;
                for (int i = 0; i < NC; i++)
                    if (!(m_trapped[i] || core_trap_valid[i])) all = 0;
                if (all) ec = 0;
            end
            if (ec < 0 && cfg_max_cycles != 0 && m_runs + 1 == cfg_max_cycles) ec = 2;
            m_runs++;
            m_trapped |= core_trap_valid;
            if (ec >= 0) begin
                m_done = 1; m_exit = ec; m_bad = bc; m_log = 0;
            end else begin
                m_log = win(m_runs);
            end
        end else if (m_t >= RC) begin
            if (init_ready) begin
                m_started = 1;
                m_log = win(0);
            end
        end else begin
            m_t++;
        end
    endtask

    // One clock: advance the model with the present inputs, then compare.
    task automatic tick();
        model_edge();
        @(posedge clock);
        #1;
        chk("dut_reset",  dut_reset,  !m_started && m_t < RC);
        chk("init_valid", init_valid, !m_started && m_t >= RC);
        chk("step_valid", step_valid, m_started && !m_done);
        chk("cycle_cnt",  cycle_cnt,  m_runs);
        chk("log_enable", log_enable, m_log);
        chk("finish",     finish,     m_done);
        chk("exit_code",  exit_code,  m_exit);
        chk("bad_core",   bad_core,   m_bad);
    endtask

    task automatic clr();
        init_ready = 0; step_err = 0; core_trap_valid = '0; core_trap_code = '0;
    endtask

    task automatic do_reset(input int n);
        clr();
        reset = 1;
        repeat (n) tick();
        reset = 0;
    endtask

    task automatic to_run();
        int k;
        do_reset(2);
        k = 0;
        while (!init_valid && k < 100) begin tick(); k++; end
        chk("init_reached", init_valid, 1);
        init_ready = 1;
        tick();
        clr();
    endtask

    task automatic trap(input logic [NC-1:0] v);
        core_trap_valid = v;
        tick();
        clr();
        tick();
    endtask

    initial begin
        int n;
        int steps;
        int lc;

        // Reset state and hold window.
        do_reset(3);
        chk("rst_dut_reset", dut_reset, 1);
        chk("rst_cycle_cnt", cycle_cnt, 0);
        chk("rst_finish", finish, 0);
        n = 0;
        while (dut_reset && n < 50) begin n++; tick(); end
        chk("hold_len", n, RC);
        chk("init_after_hold", init_valid, 1);

        // Delayed init handshake.
        repeat (9) tick();
        chk("init_held", init_valid, 1);
        chk("no_step_in_init", step_valid, 0);
        init_ready = 1;
        tick();
        clr();
        chk("first_step", step_valid, 1);
        chk("first_cnt", cycle_cnt, 0);
        tick();
        chk("cnt_after_first", cycle_cnt, 1);

        // All-good traps in order 2,0,0,3,1.
        trap(4'b0100); trap(4'b0001); trap(4'b0001); trap(4'b1000);
        chk("no_finish_before_core1", finish, 0);
        core_trap_valid = 4'b0010;
        tick();
        clr();
        chk("good_finish", finish, 1);
        chk("good_exit", exit_code, 0);
        step_err = 1;
        init_ready = 1;
        repeat (3) tick();
        clr();
        chk("done_holds_exit", exit_code, 0);

        // Simultaneous bad traps, then with a step error.
        to_run();
        core_trap_valid = 4'b1010;
        core_trap_code = {8'd5, 8'd0, 8'd2, 8'd0};
        tick();
        clr();
        chk("bad_exit", exit_code, 1);
        chk("bad_core_idx", bad_core, 1);
        to_run();
        core_trap_valid = 4'b1010;
        core_trap_code = {8'd5, 8'd0, 8'd2, 8'd0};
        step_err = 1;
        tick();
        clr();
        chk("err_exit", exit_code, 3);
        chk("err_bad_core", bad_core, 0);

        // Cycle limit.
        cfg_max_cycles = 100;
        to_run();
        steps = 0; n = 0;
        while (!finish && n < 300) begin
            if (step_valid) steps++;
            tick(); n++;
        end
        chk("max_steps", steps, 100);
        chk("max_exit", exit_code, 2);
        chk("max_cnt", cycle_cnt, 100);

        cfg_max_cycles = 1;
        to_run();
        chk("max1_step", step_valid, 1);
        tick();
        chk("max1_finish", finish, 1);
        chk("max1_exit", exit_code, 2);

        cfg_max_cycles = 0;
        to_run();
        repeat (1100) tick();
        chk("unlimited_no_finish", finish, 0);
        chk("unlimited_cnt", cycle_cnt, 1100);

        // Log window and mid-run reset.
        cfg_log_begin = 5; cfg_log_end = 7;
        to_run();
        lc = 0;
        repeat (20) begin
            if (log_enable) lc++;
            tick();
        end
        chk("log_cycles", lc, 3);
        reset = 1;
        tick();
        chk("midrst_dut_reset", dut_reset, 1);
        chk("midrst_step", step_valid, 0);
        chk("midrst_cnt", cycle_cnt, 0);
        reset = 0;
        n = 0;
        while (dut_reset && n < 50) begin n++; tick(); end
        chk("replay_hold_len", n, RC);
        init_ready = 1;
        tick();
        clr();
        chk("replay_step", step_valid, 1);

        cfg_log_begin = 0; cfg_log_end = 0;
        to_run();
        chk("log00_first", log_enable, 1);
        tick();
        chk("log00_second", log_enable, 0);

        // Randomized episodes against the model.
        for (int ep = 0; ep < 30; ep++) begin
            cfg_max_cycles = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 60);
            cfg_log_begin = $urandom_range(0, 40);
            cfg_log_end = $urandom_range(0, 40);
            do_reset($urandom_range(1, 3));
            for (int c = 0; c < 150; c++) begin
                init_ready = ($urandom_range(0, 3) == 0);
                step_err = ($urandom_range(0, 63) == 0);
                for (int i = 0; i < NC; i++) begin
                    core_trap_valid[i] = ($urandom_range(0, 15) == 0);
                    core_trap_code[i*KW +: KW] =
                        ($urandom_range(0, 7) == 0) ? KW'($urandom_range(1, 255)) : '0;
                end
                reset = ($urandom_range(0, 199) == 0);
                tick();
            end
            clr();
            reset = 0;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
